uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//   Shares the single UART transmitter between two byte producers: req0 is the CPU store path to UART_ADDR, req1 is a debug/trace source.
//   Round-robin arbitration admits at most one byte per cycle into a shared FIFO.
//   Pacing FSM pops the FIFO and pulses the UART write strobe no faster than one byte per BYTE_GAP_CYCLES.
//   The CPU therefore never overruns the UART. Sits between the CPU memory-access stage and the uart instance.
// PARAMETERS
//   FIFO_DEPTH       8     byte entries; power of two, >=2
//   BYTE_GAP_CYCLES  8680  clk cycles between wr strobes (10 bits @115200 baud, 100 MHz); >=2
// PORTS
//   clk           in   1   system clock, rising edge
//   rst           in   1   asynchronous, active-high reset
//   req0_valid    in   1   CPU byte offered
//   req0_data     in   8   CPU byte
//   req0_ready    out  1   CPU byte accepted this cycle when valid&ready
//   req1_valid    in   1   debug byte offered
//   req1_data     in   8   debug byte
//   req1_ready    out  1   debug byte accepted this cycle when valid&ready
//   uart_wr_o     out  1   one-cycle write strobe to uart (uart_wr_i)
//   uart_dat_o    out  8   byte to uart (uart_dat_i); stable while uart_wr_o=1
//   fifo_level    out  $clog2(FIFO_DEPTH)+1  entries currently held
//   idle          out  1   FIFO empty and FSM in IDLE
// BEHAVIOUR
//   Reset (async, immediate): FIFO flushed, level=0, FSM=IDLE, gap counter=0, rr pointer->req0.
//     Reset outputs: uart_wr_o=0, uart_dat_o=8'h00, idle=1. req*_ready=0 while rst=1.
//     Reset mid-byte drops queued bytes and any in-progress gap.
//   Arbitration (combinational ready):
//     FIFO full -> both ready=0.
//     Not full, one valid -> that requester gets ready=1.
//     Both valid -> requester != last_granted gets ready=1; last_granted updates on each accept.
//     Ready ignores a same-cycle pop; a full FIFO accepts nothing even while popping.
//   Valid/ready: requester holds valid and data stable until accepted; no combinational path valid->own ready beyond the rule above.
//   FIFO: push on accept, pop on SEND; simultaneous push+pop keeps level unchanged; pointers wrap modulo FIFO_DEPTH.
//   FSM states:
//     IDLE: FIFO non-empty -> SEND next cycle.
//     SEND: uart_wr_o=1, uart_dat_o=head byte, pop; -> GAP.
//     GAP:  count cycles; at count end, non-empty -> SEND, else -> IDLE.
//   Timing:
//     Back-to-back strobes are exactly BYTE_GAP_CYCLES cycles apart (strobe edge to strobe edge).
//     Strobe is never closer than BYTE_GAP_CYCLES after the previous one, even after passing through IDLE.
//     Latency: byte accepted at edge t into an empty FIFO with FSM IDLE -> uart_wr_o high in cycle t+2.
//   uart_dat_o holds the last sent byte between strobes. Counter width $clog2(BYTE_GAP_CYCLES).
// CONFIGURATION
//   UART_TX_SCHED_STATS_EN defined:
//     Adds outputs stat_sent0[31:0] and stat_sent1[31:0]: bytes accepted from req0/req1.
//     Each counter +1 per accept, wraps at 2^32, reset to 0.
//   UART_TX_SCHED_STATS_EN undefined: ports and counters absent; behaviour otherwise identical.
// TESTING (bench uses FIFO_DEPTH=4, BYTE_GAP_CYCLES=4)
//   1. Single byte: req0 0x41 accepted at edge 10 -> uart_wr_o=1, uart_dat_o=0x41 in cycle 12 only; idle=1 from cycle 13.
//   2. Both valid continuously, req0 0xA0..., req1 0xB0...:
//      accepts alternate req0,req1,req0,... (rr starts at req0);
//      strobes every 4 cycles carrying A0,B0,A1,B1.
//   3. Fill: 5 back-to-back req0 bytes while the FSM is blocked in GAP:
//      4 accepted, fifo_level=4, req0_ready=0;
//      5th accepted the cycle after the next pop, level stays 4.
//   4. Gap rule: byte arrives 1 cycle after the previous strobe with FIFO otherwise empty -> next strobe exactly 4 cycles after the previous one.
//   5. Reset mid-operation: rst=1 with level=3 during GAP -> same cycle uart_wr_o=0, idle=1, level=0; after release no strobe without new input.
//   6. STATS_EN: 3 req0 + 2 req1 accepts -> stat_sent0=3, stat_sent1=2; reset clears both to 0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin merge of two byte producers into a FIFO, drained into
//            the UART at most once per BYTE_GAP_CYCLES clocks.
// Option   : UART_TX_SCHED_STATS_EN adds per-requester accept counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_scheduler #(
    parameter int FIFO_DEPTH      = 8,
    parameter int BYTE_GAP_CYCLES = 8680
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req0_valid,
    input  logic [7:0]                    req0_data,
    output logic                          req0_ready,
    input  logic                          req1_valid,
    input  logic [7:0]                    req1_data,
    output logic                          req1_ready,
    output logic                          uart_wr_o,
    output logic [7:0]                    uart_dat_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          idle
`ifdef UART_TX_SCHED_STATS_EN
    ,
    output logic [31:0]                   stat_sent0,
    output logic [31:0]                   stat_sent1
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(BYTE_GAP_CYCLES);
    localparam logic [PW:0]   c_FULL     = (PW+1)'(FIFO_DEPTH);
    // Loaded on leaving SEND so the next SEND lands exactly BYTE_GAP_CYCLES later.
    localparam logic [CW-1:0] c_GAP_LOAD = CW'(BYTE_GAP_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            wr_q;
    logic [7:0]      dat_q;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW:0]     level_q;
    logic [PW:0]     level_d;
    logic            last_q;
    logic            full;
    logic            push;
    logic            pop;
    logic [7:0]      push_data;

    always_comb begin
        full       = (level_q == c_FULL);
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!rst && !full) begin
            if (req0_valid && req1_valid) begin
                req0_ready = last_q;
                req1_ready = !last_q;
            end else begin
                req0_ready = req0_valid;
                req1_ready = req1_valid;
            end
        end
        push      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        push_data = req1_ready ? req1_data : req0_data;
        pop       = (state_q == SEND);
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // last_q=1 means req1 was granted last, so req0 wins the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            last_q   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
                last_q   <= req1_ready;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // The gap counter keeps running through IDLE so a late byte still honours spacing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            wr_q <= 1'b0;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            case (state_q)
                IDLE, GAP: begin
                    if (cnt_q == '0) begin
                        if (level_q != '0) begin
                            state_q <= SEND;
                            wr_q    <= 1'b1;
                            dat_q   <= mem_q[rd_ptr_q];
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                SEND: begin
                    cnt_q   <= c_GAP_LOAD;
                    state_q <= (level_d == '0) ? IDLE : GAP;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign uart_wr_o  = wr_q;
    assign uart_dat_o = dat_q;
    assign fifo_level = level_q;
    assign idle       = (state_q == IDLE) && (level_q == '0);

`ifdef UART_TX_SCHED_STATS_EN
    logic [31:0] stat0_q;
    logic [31:0] stat1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            if (req0_valid && req0_ready) begin
                stat0_q <= stat0_q + 32'd1;
            end
            if (req1_valid && req1_ready) begin
                stat1_q <= stat1_q + 32'd1;
            end
        end
    end

    assign stat_sent0 = stat0_q;
    assign stat_sent1 = stat1_q;
`endif

endmodule

`default_nettype wire
